// File: rtl/wino_pin_framer.sv
// rtl/wino_pin_framer.sv - pad-side framer: serial D words in, parallel tile to core, serial Z words out
// Optional pad-test loopback is built when WPF_LOOPBACK_EN is defined (adds the lpbk input).
module wino_pin_framer #(
   parameter int DATA_W    = 10,
   parameter int IN_WORDS  = 36,
   parameter int OUT_WORDS = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_W-1:0]           D,
   input  logic                        D_vld,
   output logic                        D_rdy,
   output logic [DATA_W-1:0]           Z,
   output logic                        Z_vld,
   input  logic                        Z_rdy,
   output logic [DATA_W*IN_WORDS-1:0]  core_in,
   output logic                        core_start,
   input  logic [DATA_W*OUT_WORDS-1:0] core_out,
   input  logic                        core_done,
   output logic [7:0]                  frm_cnt,
`ifdef WPF_LOOPBACK_EN
   input  logic                        lpbk,
`endif
   output logic                        err
);

   localparam int IN_IDX_W  = (IN_WORDS  > 1) ? $clog2(IN_WORDS)  : 1;
   localparam int OUT_IDX_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
   localparam int CNT_W     = (IN_IDX_W > OUT_IDX_W) ? IN_IDX_W : OUT_IDX_W;
   localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(IN_WORDS - 1);
   localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(OUT_WORDS - 1);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W-1:0]  ibuf [IN_WORDS];
   logic [DATA_W-1:0]  obuf [OUT_WORDS];
   logic               lpbk_sel;

`ifdef WPF_LOOPBACK_EN
   assign lpbk_sel = lpbk;
`else
   assign lpbk_sel = 1'b0;
`endif

   // Z only carries data while draining; Z_vld is a register, so Z never depends on Z_rdy
   assign Z = Z_vld ? obuf[cnt[OUT_IDX_W-1:0]] : '0;

   // Present the whole input tile to the core in parallel
   always_comb begin
      core_in = '0;
      for (int k = 0; k < IN_WORDS; k++) begin
         core_in[k*DATA_W +: DATA_W] = ibuf[k];
      end
   end

   // Frame sequencer: collect tile, kick core, capture result, drain result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_LOAD;
         cnt        <= '0;
         D_rdy      <= 1'b1;
         Z_vld      <= 1'b0;
         core_start <= 1'b0;
         frm_cnt    <= 8'd0;
         err        <= 1'b0;
         for (int k = 0; k < IN_WORDS; k++) ibuf[k] <= '0;
         for (int k = 0; k < OUT_WORDS; k++) obuf[k] <= '0;
      end else begin
         // A done pulse is only legal while waiting on the core; otherwise flag and ignore it
         if (core_done && (state != S_WAIT)) err <= 1'b1;

         case (state)
            S_LOAD: begin
               if (D_vld) begin
                  ibuf[cnt[IN_IDX_W-1:0]] <= D;
                  if (cnt == LAST_IN) begin
                     cnt   <= '0;
                     D_rdy <= 1'b0;
                     if (lpbk_sel) begin
                        // Pad test: echo the head of the input tile; last word comes straight from D
                        for (int k = 0; k < OUT_WORDS; k++) begin
                           obuf[k] <= (k == IN_WORDS - 1) ? D : ibuf[k];
                        end
                        Z_vld <= 1'b1;
                        state <= S_DRAIN;
                     end else begin
                        core_start <= 1'b1;
                        state      <= S_START;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            S_START: begin
               core_start <= 1'b0;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               if (core_done) begin
                  for (int k = 0; k < OUT_WORDS; k++) begin
                     obuf[k] <= core_out[k*DATA_W +: DATA_W];
                  end
                  Z_vld <= 1'b1;
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (Z_rdy) begin
                  if (cnt == LAST_OUT) begin
                     cnt     <= '0;
                     frm_cnt <= frm_cnt + 8'd1;
                     Z_vld   <= 1'b0;
                     D_rdy   <= 1'b1;
                     state   <= S_LOAD;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= S_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wino_pin_framer.sv
// tb/tb_wino_pin_framer.sv - self-checking bench for wino_pin_framer
module tb_wino_pin_framer;

   localparam int DATA_W       = 10;
   localparam int IN_WORDS     = 36;
   localparam int OUT_WORDS    = 16;
   localparam int FRAME_BUDGET = 2000;

   typedef logic [DATA_W-1:0] word_t;

   typedef struct {
      string name;
      int    d_kind;
      int    o_kind;
      int    gap;
      int    lat;
      int    stall_at;
      int    stall_len;
      word_t exp_z0;
      word_t exp_zlast;
   } frame_vec_t;

   logic                        clk = 1'b0;
   logic                        rst = 1'b1;
   word_t                       D = '0;
   logic                        D_vld = 1'b0;
   logic                        D_rdy;
   word_t                       Z;
   logic                        Z_vld;
   logic                        Z_rdy = 1'b0;
   logic [DATA_W*IN_WORDS-1:0]  core_in;
   logic                        core_start;
   logic [DATA_W*OUT_WORDS-1:0] core_out = '0;
   logic                        core_done = 1'b0;
   logic [7:0]                  frm_cnt;
   logic                        err;
`ifdef WPF_LOOPBACK_EN
   logic                        lpbk = 1'b0;
`endif

   int    n_tests = 0;
   int    n_fail = 0;
   int    frames_done = 0;
   logic  err_exp = 1'b0;
   word_t d_words [IN_WORDS];
   word_t o_words [OUT_WORDS];

   wino_pin_framer #(.DATA_W(DATA_W), .IN_WORDS(IN_WORDS), .OUT_WORDS(OUT_WORDS)) dut (
      .clk        (clk),
      .rst        (rst),
      .D          (D),
      .D_vld      (D_vld),
      .D_rdy      (D_rdy),
      .Z          (Z),
      .Z_vld      (Z_vld),
      .Z_rdy      (Z_rdy),
      .core_in    (core_in),
      .core_start (core_start),
      .core_out   (core_out),
      .core_done  (core_done),
      .frm_cnt    (frm_cnt),
`ifdef WPF_LOOPBACK_EN
      .lpbk       (lpbk),
`endif
      .err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d", name, act, req);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int dk, input int ok);
      for (int k = 0; k < IN_WORDS; k++) begin
         case (dk)
            0:       d_words[k] = word_t'(k);
            1:       d_words[k] = word_t'(1023 - k);
            default: d_words[k] = word_t'($urandom);
         endcase
      end
      for (int k = 0; k < OUT_WORDS; k++) begin
         case (ok)
            0:       o_words[k] = word_t'(100 + k);
            1:       o_words[k] = word_t'(512 + 3 * k);
            2:       o_words[k] = word_t'((k * 37) % 1024);
            default: o_words[k] = word_t'($urandom);
         endcase
      end
   endtask

   task automatic do_reset(input string name);
      rst = 1'b0;
      D_vld = 1'b0;
      Z_rdy = 1'b0;
      core_done = 1'b0;
      #1;
      check({name, ".d_rdy"}, D_rdy, 1);
      check({name, ".z_vld"}, Z_vld, 0);
      check({name, ".z"}, Z, 0);
      check({name, ".core_start"}, core_start, 0);
      check({name, ".err"}, err, 0);
      check({name, ".frm_cnt"}, frm_cnt, 0);
      @(negedge clk);
      rst = 1'b1;
      frames_done = 0;
      err_exp = 1'b0;
      step;
   endtask

   // Drives one frame from the pad side and plays the core; expected Z stream is
   // the core result (or the head of the input tile in loopback), in order.
   task automatic run_frame(input string name, input int gap_mode, input int lat,
                            input int stall_at, input int stall_len, input bit zr_rand,
                            input bit lb, input int abort_at,
                            output word_t z_first, output word_t z_last, output bit aborted);
      word_t exp_q[$];
      word_t got_q[$];
      int    sent, starts, cd, stall_rem, cyc;
      int    bad_rdy, bad_vld, bad_time, bad_hold, bad_in, bad_str;
      bit    last_prev, done_prev, done_given, z_on, v;
      sent = 0; starts = 0; cd = 0; stall_rem = stall_len; cyc = 0;
      bad_rdy = 0; bad_vld = 0; bad_time = 0; bad_hold = 0; bad_in = 0; bad_str = 0;
      last_prev = 0; done_prev = 0; done_given = 0; z_on = 0;
      aborted = 0;
      z_first = 'x;
      z_last = 'x;
      for (int k = 0; k < OUT_WORDS; k++) exp_q.push_back(lb ? d_words[k] : o_words[k]);
`ifdef WPF_LOOPBACK_EN
      lpbk = lb;
`endif
      while (got_q.size() < OUT_WORDS && cyc < FRAME_BUDGET) begin
         if (abort_at >= 0 && got_q.size() == abort_at) begin
            aborted = 1;
            D_vld = 1'b0;
            Z_rdy = 1'b0;
            return;
         end
         if (last_prev) begin
            if (lb) begin
               if (Z_vld !== 1'b1 || Z !== d_words[0]) bad_time++;
            end else if (core_start !== 1'b1) begin
               bad_time++;
            end
         end
         if (done_prev && (Z_vld !== 1'b1 || Z !== exp_q[0])) bad_time++;
         if (D_rdy !== (sent < IN_WORDS)) bad_rdy++;
         if (Z_vld !== 1'b1 && Z !== '0) bad_vld++;
         if (Z_vld === 1'b1 && (sent < IN_WORDS || (!lb && !done_given))) bad_vld++;
         if (z_on && Z_vld !== 1'b1) bad_vld++;
         if (Z_vld === 1'b1) z_on = 1;
         if (core_start === 1'b1) begin
            starts++;
            for (int k = 0; k < IN_WORDS; k++) begin
               if (core_in[k*DATA_W +: DATA_W] !== d_words[k]) bad_in++;
            end
            cd = lat + 1;
         end

         last_prev = 0;
         done_prev = 0;
         core_done = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               core_done = 1'b1;
               for (int k = 0; k < OUT_WORDS; k++) core_out[k*DATA_W +: DATA_W] = o_words[k];
               done_prev = 1;
               done_given = 1;
            end
         end
         if (sent < IN_WORDS) begin
            case (gap_mode)
               0:       v = 1'b1;
               1:       v = (cyc % 2 == 0);
               default: v = 1'($urandom % 2);
            endcase
            D_vld = v;
            D = v ? d_words[sent] : word_t'($urandom);
            if (v) begin
               sent++;
               if (sent == IN_WORDS) last_prev = 1;
            end
         end else begin
            D_vld = 1'($urandom % 2);
            D = word_t'($urandom);
         end
         if (Z_vld === 1'b1) begin
            if (got_q.size() == stall_at && stall_rem > 0) begin
               Z_rdy = 1'b0;
               stall_rem--;
               if (Z !== exp_q[stall_at]) bad_hold++;
            end else begin
               Z_rdy = zr_rand ? 1'($urandom % 2) : 1'b1;
            end
            if (Z_rdy) got_q.push_back(Z);
         end else begin
            Z_rdy = 1'($urandom % 2);
         end
         cyc++;
         step;
      end
      core_done = 1'b0;
      D_vld = 1'b0;
      Z_rdy = 1'b0;
      frames_done++;
      check({name, ".budget"}, cyc < FRAME_BUDGET, 1);
      if (got_q.size() != OUT_WORDS) bad_str++;
      for (int k = 0; k < got_q.size() && k < OUT_WORDS; k++) begin
         if (got_q[k] !== exp_q[k]) bad_str++;
      end
      if (got_q.size() > 0) z_first = got_q[0];
      if (got_q.size() == OUT_WORDS) z_last = got_q[OUT_WORDS-1];
      for (int k = 0; k < IN_WORDS; k++) begin
         if (core_in[k*DATA_W +: DATA_W] !== d_words[k]) bad_in++;
      end
      check({name, ".stream_errs"}, bad_str, 0);
      check({name, ".core_in_errs"}, bad_in, 0);
      check({name, ".starts"}, starts, lb ? 0 : 1);
      check({name, ".d_rdy_errs"}, bad_rdy, 0);
      check({name, ".z_vld_errs"}, bad_vld, 0);
      check({name, ".timing_errs"}, bad_time, 0);
      check({name, ".hold_errs"}, bad_hold, 0);
      check({name, ".end_d_rdy"}, D_rdy, 1);
      check({name, ".end_z_vld"}, Z_vld, 0);
      check({name, ".frm_cnt"}, frm_cnt, frames_done % 256);
      check({name, ".err"}, err, err_exp);
   endtask

   initial begin
      frame_vec_t vecs [4];
      word_t      zf, zl;
      bit         ab, lbr;

      vecs[0] = '{"single", 0, 0, 0,  5, -1, 0, 10'd100, 10'd115};
      vecs[1] = '{"bp",     0, 0, 1,  5,  7, 3, 10'd100, 10'd115};
      vecs[2] = '{"inv",    1, 1, 0,  1, -1, 0, 10'd512, 10'd557};
      vecs[3] = '{"mixed",  2, 2, 2, 12,  3, 2, 10'd0,   10'd555};

      #1;
      do_reset("rst0");

      for (int i = 0; i < 4; i++) begin
         fill(vecs[i].d_kind, vecs[i].o_kind);
         run_frame(vecs[i].name, vecs[i].gap, vecs[i].lat, vecs[i].stall_at,
                   vecs[i].stall_len, 1'b0, 1'b0, -1, zf, zl, ab);
         check({vecs[i].name, ".z_first"}, zf, vecs[i].exp_z0);
         check({vecs[i].name, ".z_last"}, zl, vecs[i].exp_zlast);
      end

      // Stray core_done while collecting input
      core_done = 1'b1;
      step;
      core_done = 1'b0;
      check("perr.err", err, 1);
      check("perr.d_rdy", D_rdy, 1);
      check("perr.z_vld", Z_vld, 0);
      check("perr.core_start", core_start, 0);
      err_exp = 1'b1;
      fill(0, 0);
      run_frame("after_err", 0, 5, -1, 0, 1'b0, 1'b0, -1, zf, zl, ab);
      check("after_err.z_first", zf, 100);

      // Frame counter wrap
      do_reset("rst_wrap");
      for (int f = 0; f < 256; f++) begin
         fill(2, 3);
         run_frame("wrap", 0, 1, -1, 0, 1'b0, 1'b0, -1, zf, zl, ab);
      end
      check("wrap.frm_cnt_256", frm_cnt, 0);
      fill(0, 0);
      run_frame("wrap257", 0, 3, -1, 0, 1'b0, 1'b0, -1, zf, zl, ab);
      check("wrap257.frm_cnt", frm_cnt, 1);
      check("wrap257.z_first", zf, 100);

      // Reset in the middle of a drain
      fill(0, 0);
      run_frame("abort", 0, 5, -1, 0, 1'b0, 1'b0, 5, zf, zl, ab);
      check("abort.reached", ab, 1);
      check("abort.z_vld_before", Z_vld, 1);
      do_reset("rst_drain");
      fill(1, 1);
      run_frame("fresh", 0, 4, -1, 0, 1'b0, 1'b0, -1, zf, zl, ab);
      check("fresh.z_first", zf, 512);
      check("fresh.z_last", zl, 557);

`ifdef WPF_LOOPBACK_EN
      fill(1, 0);
      run_frame("lpbk", 0, 5, -1, 0, 1'b0, 1'b1, -1, zf, zl, ab);
      check("lpbk.z_first", zf, 10'h3FF);
      check("lpbk.z_last", zl, 10'h3F0);
      fill(0, 0);
      run_frame("post_lpbk", 0, 5, -1, 0, 1'b0, 1'b0, -1, zf, zl, ab);
      check("post_lpbk.z_first", zf, 100);
`endif

      // Randomized frames against the stream model
      for (int r = 0; r < 24; r++) begin
         lbr = 1'b0;
`ifdef WPF_LOOPBACK_EN
         lbr = ($urandom % 4 == 0);
`endif
         fill(2, 3);
         run_frame("rand", 2, int'($urandom_range(1, 8)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 1'b1, lbr, -1, zf, zl, ab);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wino_pin_framer.md
# wino_pin_framer

Pin-limited frame interface between the chip pads and a Winograd tile core. It collects one input tile as a stream of narrow words from the D pins and hands it to the core as a parallel bundle with a start pulse. It then captures the core's parallel result and streams it back out on the Z pins. It sits directly inside the pad ring, replacing a direct D/Z hookup, so that tile sizes larger than the pin count can be serviced.

## Interface
- DATA_W, 10, width of one pin word (D and Z buses)
- IN_WORDS, 36, words per input tile (6x6 for F(4x4,3x3))
- OUT_WORDS, 16, words per output tile (4x4)
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous and active-low
- D  input  DATA_W  input word from pads
- D_vld  input  1  D holds a valid word
- D_rdy  output  1  framer accepts a word this cycle
- Z  output  DATA_W  output word to pads
- Z_vld  output  1  Z holds a valid word
- Z_rdy  input  1  pad side accepts Z this cycle
- core_in  output  DATA_W*IN_WORDS  input tile; word k at bits [k*DATA_W +: DATA_W]
- core_start  output  1  one-cycle start pulse to the core
- core_out  input  DATA_W*OUT_WORDS  result tile, same packing as core_in
- core_done  input  1  one-cycle pulse; core_out is valid in the same cycle
- frm_cnt  output  8  completed frames, wraps 255->0
- err  output  1  sticky protocol error flag

## Operation
- FSM states: LOAD, START, WAIT, DRAIN. Reset state is LOAD.
- LOAD
  - D_rdy=1.
  - Each accepted word (D_vld&&D_rdy) is written to ibuf[cnt], then cnt++.
  - When word IN_WORDS-1 is accepted: cnt clears and the FSM goes to START.
- START
  - core_start=1 for exactly one cycle, then the FSM goes to WAIT.
- WAIT
  - core_done=1 loads obuf from core_out, and the FSM goes to DRAIN.
- DRAIN
  - Z_vld=1 and Z=obuf[cnt].
  - On Z_rdy, cnt++.
  - When word OUT_WORDS-1 is accepted: cnt clears, frm_cnt++, and the FSM goes to LOAD.
- core_in is driven from ibuf at all times. ibuf is written only in LOAD, so core_in is stable from START until the next frame's first accepted word.
- Outside LOAD, D_rdy=0 and D is ignored.
- Outside DRAIN, Z_vld=0 and Z=0.
- core_done in any state other than WAIT sets err=1. The pulse is otherwise ignored and does not change state. err is cleared only by reset.
- Reset asserted mid-frame aborts the frame. A partial ibuf is discarded, and the next frame starts at word 0.

## Timing
- Reset values:
  - D_rdy=1, Z_vld=0, Z=0
  - core_start=0, frm_cnt=0, err=0
  - cnt=0, and ibuf and obuf all 0
- Last input word accepted at edge N: core_start=1 in cycle N+1, state is WAIT from N+2.
- core_done sampled at edge M: Z_vld=1 with Z=obuf[0] in cycle M+1.
- Z_rdy held high: one word per cycle, so a drain takes OUT_WORDS cycles.
- Z, Z_vld, D_rdy and core_start are functions of registers only. There is no combinational path from D_vld or Z_rdy to any output.
- Min frame period with no stalls: IN_WORDS + 1 + core latency + OUT_WORDS cycles.

## Configuration
- WPF_LOOPBACK_EN defined:
  - Adds port lpbk (input, 1), a pad-test mode.
  - If lpbk=1 on the edge that accepts the last input word, the FSM goes directly LOAD->DRAIN.
  - In that case obuf[k] is loaded from ibuf[k] (the final word is taken from D) for k<OUT_WORDS.
  - No core_start is issued, and frm_cnt still increments.
  - A core_done during a loopback frame sets err.
- WPF_LOOPBACK_EN undefined:
  - No lpbk port, and behaviour is identical to lpbk=0.

## Test plan
- Reset check: assert rst=0 mid-clock → D_rdy=1, Z_vld=0, core_start=0, err=0, frm_cnt=0 immediately, without waiting for a clock edge.
- Single frame, no stalls, core model with 5-cycle latency:
  - Stimulus: stream D=0..35, core_out word k = 100+k.
  - Response: core_in word k = k; one core_start pulse; Z = 100..115 on consecutive cycles; frm_cnt=1.
- Backpressure and gaps:
  - Stimulus: D_vld toggles every other cycle; Z_rdy=0 for 3 cycles at word 7.
  - Response: no lost or duplicated words; Z holds 107 while stalled; output sequence unchanged.
- Protocol error: core_done pulsed during LOAD → err=1, state stays LOAD, and err persists over the next good frame.
- Wrap: run 256 frames → frm_cnt reads 0 after the 256th drain; the 257th frame completes normally.
- Loopback (WPF_LOOPBACK_EN, lpbk=1):
  - Stimulus: stream D=0x3FF-k.
  - Response: core_start never asserts; Z = 0x3FF..0x3F0 (16 words).
- Reset mid-DRAIN: apply reset after word 5 → Z_vld=0, then a fresh frame drains from word 0.
